dmem_responder: RTL



---
 rtl/mips_mem_pkg.sv | 31 +++
 rtl/dmem_responder_if.sv | 35 +++
 rtl/dmem_array.sv | 45 ++++
 rtl/dmem_responder.sv | 129 ++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and limits for the data-memory responder: FSM states, captured
// request record and the request fault decode.
package mips_mem_pkg;

    localparam int DEPTH_DEFAULT = 64;
    localparam int LATENCY_MIN   = 1;
    localparam int LATENCY_MAX   = 15;
    localparam int CNT_W         = $clog2(LATENCY_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        write;
        logic        read;
    } req_t;

    // Misaligned, beyond the word store, or not exactly one of read/write.
    function automatic logic req_fault(input req_t req, input int aw);
        return (req.addr[1:0] != 2'b00)
            || ((req.addr >> (aw + 2)) != 32'd0)
            || (req.read == req.write);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Core-to-memory request/response bus. Optional byte-enable lane is present
// only when DMEM_BYTE_STROBE_EN is defined.
interface dmem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_write;
    logic        req_read;
`ifdef DMEM_BYTE_STROBE_EN
    logic [3:0]  req_be;
`endif
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
`ifdef DMEM_BYTE_STROBE_EN
        output req_be,
`endif
        output req_valid, req_addr, req_wdata, req_write, req_read, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
`ifdef DMEM_BYTE_STROBE_EN
        input  req_be,
`endif
        input  req_valid, req_addr, req_wdata, req_write, req_read, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/dmem_array.sv
// DEPTH x 32 word store: synchronous byte-lane write, synchronous read into a
// resettable output register that can also be cleared to zero.
module dmem_array
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic          i_re,
    input  logic          i_clr,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    // NOTE: the storage array has no reset; contents survive rst_n and a reset
    // branch here would turn the RAM into a huge bank of flops.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < 4; i++) begin
                if (i_be[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_clr) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with programmable latency.
// Define DMEM_BYTE_STROBE_EN to enable per-byte store strobes (req_be).
module dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEFAULT,
    parameter int LATENCY = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_responder_if.slave bus
);

    localparam int AW  = $clog2(DEPTH);
    localparam int LAT = (LATENCY < LATENCY_MIN) ? LATENCY_MIN :
                         (LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY;
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'((LAT >= 2) ? LAT - 2 : 0);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    req_t             r_req;
    logic             r_req_ready;
    logic             r_resp_valid;
    logic             r_resp_err;

    req_t             w_in;
    req_t             w_cmt;
    logic             w_accept;
    logic             w_go;
    logic             w_fault;
    logic             w_we;
    logic             w_re;
    logic             w_clr;
    logic             w_resp_hs;
    logic [AW-1:0]    w_idx;
    logic [31:0]      w_rdata;

    // NOTE: combinational logic uses blocking assignments and writes every
    // signal unconditionally, so no path can infer a latch.
    always_comb begin
        w_in.addr  = bus.req_addr;
        w_in.wdata = bus.req_wdata;
        w_in.write = bus.req_write;
        w_in.read  = bus.req_read;
`ifdef DMEM_BYTE_STROBE_EN
        w_in.be    = bus.req_be;
`else
        w_in.be    = 4'hF;
`endif
        w_accept  = bus.req_valid && r_req_ready;
        // With LAT==1 the commit happens on the accepting edge, straight from the bus.
        w_cmt     = (r_state == IDLE) ? w_in : r_req;
        w_go      = ((r_state == IDLE) && w_accept && (LAT == 1))
                 || ((r_state == WAIT) && (r_cnt == LAST_WAIT));
        w_fault   = req_fault(w_cmt, AW);
        w_idx     = w_cmt.addr[AW+1:2];
        w_we      = w_go && !w_fault && w_cmt.write;
        w_re      = w_go && !w_fault && w_cmt.read;
        w_resp_hs = r_resp_valid && bus.resp_ready;
        w_clr     = (w_go && !w_re) || w_resp_hs;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_req        <= '0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_req       <= w_in;
                        r_cnt       <= '0;
                        r_req_ready <= 1'b0;
                        if (w_go) begin
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= w_fault;
                        end else begin
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (w_go) begin
                        r_state      <= RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= w_fault;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (w_resp_hs) begin
                        r_state      <= IDLE;
                        r_req_ready  <= 1'b1;
                        r_resp_valid <= 1'b0;
                        r_resp_err   <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_we),
        .i_re    (w_re),
        .i_clr   (w_clr),
        .i_be    (w_cmt.be),
        .i_addr  (w_idx),
        .i_wdata (w_cmt.wdata),
        .o_rdata (w_rdata)
    );

    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_err   = r_resp_err;
    assign bus.resp_rdata = w_rdata;

endmodule
